// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and port indices.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory model.
// slave = arbiter view; master = requesters + memory view.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          r0_req, r0_we, r0_ack;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_req, r1_we, r1_ack;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          owner, err;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  mem_ack, mem_rdata,
    output r0_ack, r0_rdata, r1_ack, r1_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output owner, err
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output mem_ack, mem_rdata,
    input  r0_ack, r0_rdata, r1_ack, r1_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  owner, err
  );
endinterface

// File: rtl/mem_arb_timer.sv
// BUSY-phase watchdog: counts non-acked cycles and flags expiry at LIMIT-1.
module mem_arb_timer #(
  parameter int LIMIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(LIMIT);

  logic [CW-1:0] cnt;

  assign expire = (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (en && !expire) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between CPU (port 0) and aux (port 1).
// Define MEM_ARBITER_TIMEOUT_EN to abort memory accesses that stall for TIMEOUT cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic           clock,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);
  if (TIMEOUT < 2) begin : g_bad_cfg
    $error("mem_arbiter: TIMEOUT must be >= 2");
  end

  state_e        state;
  logic          prio;
  logic [1:0]    req;
  logic          winner, tmo;
  logic [DW-1:0] done_rdata;

  assign req    = {bus.r1_req, bus.r0_req};
  // Contention goes to prio; a lone requester wins outright.
  assign winner = (&req) ? prio : req[PORT_AUX];
  assign done_rdata = (bus.mem_ack && !bus.mem_we) ? bus.mem_rdata : '0;

`ifdef MEM_ARBITER_TIMEOUT_EN
  logic expire;

  mem_arb_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clr    (state != BUSY),
    .en     (state == BUSY && !bus.mem_ack),
    .expire (expire)
  );

  assign tmo = expire;
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      prio          <= PORT_CPU;
      bus.owner     <= PORT_CPU;
      bus.err       <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.r0_ack    <= 1'b0;
      bus.r1_ack    <= 1'b0;
      bus.r0_rdata  <= '0;
      bus.r1_rdata  <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          bus.owner     <= winner;
          prio          <= ~winner;
          bus.mem_req   <= 1'b1;
          bus.mem_we    <= winner ? bus.r1_we    : bus.r0_we;
          bus.mem_addr  <= winner ? bus.r1_addr  : bus.r0_addr;
          bus.mem_wdata <= winner ? bus.r1_wdata : bus.r0_wdata;
          state         <= BUSY;
        end
        // mem_ack beats an expiry landing in the same cycle.
        BUSY: if (bus.mem_ack || tmo) begin
          bus.mem_req <= 1'b0;
          bus.err     <= !bus.mem_ack;
          if (bus.owner == PORT_CPU) begin
            bus.r0_ack   <= 1'b1;
            bus.r0_rdata <= done_rdata;
          end else begin
            bus.r1_ack   <= 1'b1;
            bus.r1_rdata <= done_rdata;
          end
          state <= RESP;
        end
        RESP: begin
          bus.r0_ack <= 1'b0;
          bus.r1_ack <= 1'b0;
          bus.err    <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a scripted wait-state memory responder.
// Timeout scenarios run only when MEM_ARBITER_TIMEOUT_EN is defined.
module tb_mem_arbiter;
  logic clock, reset;
  int   vectors = 0;
  int   miscompares = 0;

  // memory responder knobs
  logic        mem_en;
  int          mem_delay;
  int          wait_cnt;
  logic [31:0] rd_value;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Acks after mem_delay wait cycles of mem_req being high.
  always @(posedge clock) begin
    #1;
    if (!bus.mem_req) begin
      bus.mem_ack = 1'b0;
      wait_cnt    = 0;
    end else if (!mem_en) begin
      bus.mem_ack = 1'b0;
    end else if (wait_cnt == mem_delay) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rd_value;
    end else begin
      bus.mem_ack = 1'b0;
      wait_cnt    = wait_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset();
    vectors++;
    if (bus.mem_req !== 1'b0 || bus.r0_ack !== 1'b0 || bus.r1_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: mem_req=%b r0_ack=%b r1_ack=%b want 0 0 0", bus.mem_req, bus.r0_ack, bus.r1_ack);
    end
    vectors++;
    if (bus.owner !== 1'b0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_owner_err: owner=%b err=%b want 0 0", bus.owner, bus.err);
    end
    vectors++;
    if (bus.r0_rdata !== 32'h0 || bus.r1_rdata !== 32'h0 || bus.mem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: r0_rdata=%h r1_rdata=%h mem_addr=%h want 0", bus.r0_rdata, bus.r1_rdata, bus.mem_addr);
    end
  endtask

  task automatic test_contention();
    int seq[6];
    int n = 0, cnt0 = 0, cnt1 = 0, cyc = 0;
    mem_en = 1'b1; mem_delay = 0; rd_value = 32'h0000_00A0;
    bus.r0_we = 1'b0; bus.r0_addr = 32'h100;
    bus.r1_we = 1'b0; bus.r1_addr = 32'h200;
    bus.r0_req = 1'b1; bus.r1_req = 1'b1;
    while (n < 6 && cyc < 60) begin
      step();
      cyc++;
      if (bus.r0_ack && bus.r1_ack) begin
        vectors++; miscompares++;
        $display("FAIL contention_dual_ack: both acks high at cycle %0d", cyc);
      end
      if (bus.r0_ack) begin seq[n] = 0; n++; cnt0++; end
      if (bus.r1_ack) begin seq[n] = 1; n++; cnt1++; end
      bus.r0_req = (cnt0 < 3) && !bus.r0_ack;
      bus.r1_req = (cnt1 < 3) && !bus.r1_ack;
    end
    bus.r0_req = 1'b0; bus.r1_req = 1'b0;
    vectors++;
    if (n != 6 || cnt0 != 3 || cnt1 != 3) begin
      miscompares++;
      $display("FAIL contention_counts: acks=%0d p0=%0d p1=%0d want 6 3 3", n, cnt0, cnt1);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (i < n && seq[i] != (i % 2)) begin
        miscompares++;
        $display("FAIL contention_order[%0d]: owner=%0d want %0d", i, seq[i], i % 2);
      end
    end
    step();
  endtask

  task automatic test_single_read();
    mem_en = 1'b1; mem_delay = 0; rd_value = 32'hDEAD_BEEF;
    bus.r0_we = 1'b0; bus.r0_addr = 32'h10; bus.r0_wdata = 32'h0;
    bus.r0_req = 1'b1;
    vectors++;
    if (bus.mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL read_c0_mem_req: got %b want 0", bus.mem_req);
    end
    step();
    vectors++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10 || bus.mem_we !== 1'b0 || bus.owner !== 1'b0 || bus.r0_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL read_c1: mem_req=%b addr=%h we=%b owner=%b r0_ack=%b want 1 10 0 0 0",
               bus.mem_req, bus.mem_addr, bus.mem_we, bus.owner, bus.r0_ack);
    end
    step();
    vectors++;
    if (bus.r0_ack !== 1'b1 || bus.r0_rdata !== 32'hDEAD_BEEF || bus.r1_ack !== 1'b0 || bus.mem_req !== 1'b0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL read_c2: r0_ack=%b r0_rdata=%h r1_ack=%b mem_req=%b err=%b want 1 deadbeef 0 0 0",
               bus.r0_ack, bus.r0_rdata, bus.r1_ack, bus.mem_req, bus.err);
    end
    bus.r0_req = 1'b0;
    step();
    vectors++;
    if (bus.r0_ack !== 1'b0 || bus.r0_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL read_c3_hold: r0_ack=%b r0_rdata=%h want 0 deadbeef", bus.r0_ack, bus.r0_rdata);
    end
  endtask

  task automatic test_wait_states();
    mem_en = 1'b1; mem_delay = 5; rd_value = 32'hCAFE_0000;
    bus.r1_we = 1'b1; bus.r1_addr = 32'h20; bus.r1_wdata = 32'h1234;
    bus.r1_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 3) begin bus.r1_addr = 32'h99; bus.r1_wdata = 32'h5678; end
      vectors++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h20 ||
          bus.mem_wdata !== 32'h1234 || bus.owner !== 1'b1 || bus.r1_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL wait_hold_c%0d: mem_req=%b we=%b addr=%h wdata=%h owner=%b r1_ack=%b want 1 1 20 1234 1 0",
                 k, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.owner, bus.r1_ack);
      end
    end
    step();
    vectors++;
    if (bus.r1_ack !== 1'b1 || bus.r1_rdata !== 32'h0 || bus.r0_ack !== 1'b0 || bus.mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_ack: r1_ack=%b r1_rdata=%h r0_ack=%b mem_req=%b want 1 0 0 0",
               bus.r1_ack, bus.r1_rdata, bus.r0_ack, bus.mem_req);
    end
    bus.r1_req = 1'b0;
    step();
    vectors++;
    if (bus.r1_ack !== 1'b0 || bus.mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_done: r1_ack=%b mem_req=%b want 0 0", bus.r1_ack, bus.mem_req);
    end
  endtask

  task automatic test_reset_midop();
    int cyc = 0;
    mem_en = 1'b0; mem_delay = 0; rd_value = 32'h1357_9BDF;
    bus.r0_we = 1'b0; bus.r0_addr = 32'h30;
    bus.r0_req = 1'b1;
    step();
    step();
    vectors++;
    if (bus.mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_busy: mem_req=%b want 1", bus.mem_req);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.mem_req !== 1'b0 || bus.r0_ack !== 1'b0 || bus.r1_ack !== 1'b0 || bus.owner !== 1'b0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_async: mem_req=%b r0_ack=%b r1_ack=%b owner=%b err=%b want 0",
               bus.mem_req, bus.r0_ack, bus.r1_ack, bus.owner, bus.err);
    end
    step();
    reset = 1'b0;
    mem_en = 1'b1;
    bus.r1_we = 1'b0; bus.r1_addr = 32'h40;
    bus.r0_req = 1'b1; bus.r1_req = 1'b1;
    step();
    vectors++;
    if (bus.mem_req !== 1'b1 || bus.owner !== 1'b0 || bus.mem_addr !== 32'h30) begin
      miscompares++;
      $display("FAIL midop_regrant: mem_req=%b owner=%b addr=%h want 1 0 30", bus.mem_req, bus.owner, bus.mem_addr);
    end
    step();
    bus.r0_req = 1'b0;
    while (!bus.r1_ack && cyc < 20) begin step(); cyc++; end
    vectors++;
    if (!bus.r1_ack) begin
      miscompares++;
      $display("FAIL midop_drain: r1_ack never seen within 20 cycles");
    end
    bus.r1_req = 1'b0;
    step();
  endtask

`ifdef MEM_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    mem_en = 1'b0; mem_delay = 0; rd_value = 32'h0;
    bus.r0_we = 1'b0; bus.r0_addr = 32'h50;
    bus.r0_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      vectors++;
      if (bus.mem_req !== 1'b1 || bus.r0_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout_wait_c%0d: mem_req=%b r0_ack=%b want 1 0", k, bus.mem_req, bus.r0_ack);
      end
    end
    step();
    vectors++;
    if (bus.r0_ack !== 1'b1 || bus.err !== 1'b1 || bus.r0_rdata !== 32'h0 || bus.mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_abort: r0_ack=%b err=%b r0_rdata=%h mem_req=%b want 1 1 0 0",
               bus.r0_ack, bus.err, bus.r0_rdata, bus.mem_req);
    end
    bus.r0_req = 1'b0;
    step();
    vectors++;
    if (bus.r0_ack !== 1'b0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_clear: r0_ack=%b err=%b want 0 0", bus.r0_ack, bus.err);
    end
  endtask

  task automatic test_timeout_race();
    mem_en = 1'b1; mem_delay = 3; rd_value = 32'h5555_AAAA;
    bus.r0_we = 1'b0; bus.r0_addr = 32'h60;
    bus.r0_req = 1'b1;
    repeat (4) step();
    vectors++;
    if (bus.mem_req !== 1'b1 || bus.r0_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL race_c4: mem_req=%b r0_ack=%b want 1 0", bus.mem_req, bus.r0_ack);
    end
    step();
    vectors++;
    if (bus.r0_ack !== 1'b1 || bus.err !== 1'b0 || bus.r0_rdata !== 32'h5555_AAAA) begin
      miscompares++;
      $display("FAIL race_done: r0_ack=%b err=%b r0_rdata=%h want 1 0 5555aaaa", bus.r0_ack, bus.err, bus.r0_rdata);
    end
    bus.r0_req = 1'b0;
    step();
  endtask
`else
  task automatic test_no_timeout();
    mem_en = 1'b0; mem_delay = 0; rd_value = 32'h2468_ACE0;
    bus.r0_we = 1'b0; bus.r0_addr = 32'h70;
    bus.r0_req = 1'b1;
    repeat (20) step();
    vectors++;
    if (bus.mem_req !== 1'b1 || bus.r0_ack !== 1'b0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_hold: mem_req=%b r0_ack=%b err=%b want 1 0 0", bus.mem_req, bus.r0_ack, bus.err);
    end
    mem_en = 1'b1;
    step();
    step();
    vectors++;
    if (bus.r0_ack !== 1'b1 || bus.err !== 1'b0 || bus.r0_rdata !== 32'h2468_ACE0) begin
      miscompares++;
      $display("FAIL stall_done: r0_ack=%b err=%b r0_rdata=%h want 1 0 2468ace0", bus.r0_ack, bus.err, bus.r0_rdata);
    end
    bus.r0_req = 1'b0;
    step();
  endtask
`endif

  initial begin
    reset = 1'b1;
    mem_en = 1'b0; mem_delay = 0; wait_cnt = 0; rd_value = 32'h0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = 32'h0; bus.r0_wdata = 32'h0;
    bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = 32'h0; bus.r1_wdata = 32'h0;
    step();
    step();
    test_reset();
    reset = 1'b0;
    step();
    test_contention();
    test_single_read();
    test_wait_states();
    test_reset_midop();
`ifdef MEM_ARBITER_TIMEOUT_EN
    test_timeout();
    test_timeout_race();
`else
    test_no_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
